// File: rtl/irq_inject_ctrl_pkg.sv
// Shared defaults and helpers for the interrupt-instruction injector.
// A queued entry is {channel, instruction}; instruction zero is the NOP encoding and is never queued.
package irq_inject_ctrl_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int DEPTH_DEFAULT  = 4;
    localparam int IW_DEFAULT     = 32;

    // Instruction occupies the low bits of a queue entry.
    localparam int INSTR_LSB = 0;

    // Channel field sits directly above the instruction.
    function automatic int ch_lsb(input int iw);
        return iw;
    endfunction

    // Increment modulo n, valid for any n >= 1.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/irq_fifo.sv
// Synchronous FIFO with a combinational head read (no read latency).
// Pointers and occupancy reset asynchronously; storage is left unreset since the head is gated by empty.
module irq_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (count_reg == FULL_LEVEL);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/irq_inject_ctrl.sv
// Multi-channel interrupt-instruction injector: round-robin arbiter into a shared FIFO,
// drained one entry per un-stalled, un-flushed fetch slot while injection is enabled.
module irq_inject_ctrl
    import irq_inject_ctrl_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int IW     = IW_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          irq_valid,
    input  logic [NUM_CH*IW-1:0]       irq_instr,
    input  logic [NUM_CH-1:0]          irq_mask,
    output logic [NUM_CH-1:0]          irq_ready,
    input  logic                       inj_enable,
    input  logic                       pipe_stall,
    input  logic                       pipe_flush,
    output logic [IW-1:0]              inject_instr,
    output logic                       inject_valid,
    output logic [$clog2(NUM_CH)-1:0]  inject_ch,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_zero
);

    localparam int CW     = $clog2(NUM_CH);
    localparam int EW     = IW + CW;
    localparam int CH_LSB = ch_lsb(IW);

    logic [IW-1:0]     ch_instr [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic              grant_found;
    logic [CW-1:0]     grant_idx;
    logic [IW-1:0]     grant_instr;
    logic [CW-1:0]     rr_next;
    logic              accept;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     rr_ptr_reg;
    logic              err_zero_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_instr[gi] = irq_instr[gi*IW +: IW];
        assign eligible[gi] = irq_valid[gi] & ~irq_mask[gi];
    end

    // Scan from rr_ptr upward with wrap; the first eligible channel wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_instr = '0;
        rr_next     = rr_ptr_reg;
        idx         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[CW-1:0];
                grant_instr = ch_instr[idx];
                rr_next     = CW'(wrap_inc(idx, NUM_CH));
            end
        end
    end

    // Full blocks the grant even when a pop is happening this cycle; ready is held low in reset.
    assign accept = grant_found & ~fifo_full & reset;
    assign push   = accept & (grant_instr != '0);

    always_comb begin
        irq_ready = '0;
        if (accept) irq_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg   <= '0;
            err_zero_reg <= 1'b0;
        end else if (accept) begin
            rr_ptr_reg <= rr_next;
            if (grant_instr == '0) err_zero_reg <= 1'b1;
        end
    end

    irq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data ({grant_idx, grant_instr}),
        .pop     (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign inject_valid = ~fifo_empty & inj_enable;
    assign pop          = inject_valid & ~pipe_stall & ~pipe_flush;
    assign inject_instr = inject_valid ? head_entry[INSTR_LSB +: IW] : '0;
    assign inject_ch    = inject_valid ? head_entry[CH_LSB +: CW] : '0;
    assign err_zero     = err_zero_reg;

endmodule
